// File: rtl/bus_arbiter.sv
// Two-port bus arbiter: the instruction-fetch and MEM-stage data ports share one external bus.
// Optional macro ARB_STARVE_GUARD_EN forces IF through after STARVE_LIMIT back-to-back MEM grants.
module bus_arbiter #(
  parameter int unsigned TIMEOUT      = 255,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        mem_req,
  input  logic        mem_rw,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_sel,
  output logic [31:0] mem_rdata,
  output logic        mem_ack,
  output logic        stallreq,
  output logic        bus_en,
  output logic        bus_rw,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_sel,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        bus_err,
  output logic [1:0]  dbg_state
);

  // Handshake: a requester raises *_req with stable fields and holds it until it sees *_ack
  // (a one-cycle pulse); the bus side holds bus_en and all bus_* fields until bus_ack or abort.

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUSY_IF  = 2'd1,
    BUSY_MEM = 2'd2
  } state_t;

  localparam logic [9:0] TMO_LAST = 10'(TIMEOUT - 1);

  state_t     state_q;
  state_t     state_d;
  logic [9:0] tmo_q;
  logic       busy;
  logic       timeout_hit;
  logic       grant_mem;
  logic       grant_if;
  logic       done;
  logic       abort;
  logic       force_if;

  assign busy        = (state_q == BUSY_IF) || (state_q == BUSY_MEM);
  assign timeout_hit = busy && (tmo_q == TMO_LAST);
  assign dbg_state   = state_q;

  assign stallreq = (if_req & ~if_ack) | (mem_req & ~mem_ack);

`ifdef ARB_STARVE_GUARD_EN
  logic [2:0] starve_q;

  // Only counts MEM grants that overtook a waiting fetch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_q <= 3'd0;
    end else if (grant_if) begin
      starve_q <= 3'd0;
    end else if (grant_mem && if_req) begin
      starve_q <= starve_q + 3'd1;
    end
  end

  assign force_if = if_req && (starve_q == 3'(STARVE_LIMIT));
`else
  // Strict MEM priority; STARVE_LIMIT has no effect without the guard.
  assign force_if = 1'b0 && (STARVE_LIMIT != 0);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_mem = 1'b0;
    grant_if  = 1'b0;
    done      = 1'b0;
    abort     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mem_req && !force_if) begin
          grant_mem = 1'b1;
          state_d   = BUSY_MEM;
        end else if (if_req) begin
          grant_if = 1'b1;
          state_d  = BUSY_IF;
        end
      end
      BUSY_IF, BUSY_MEM: begin
        // A bus_ack arriving on the timeout edge still completes normally.
        if (bus_ack) begin
          done    = 1'b1;
          state_d = IDLE;
        end else if (timeout_hit) begin
          abort   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus_en    <= 1'b0;
      bus_rw    <= 1'b0;
      bus_addr  <= 32'h0;
      bus_wdata <= 32'h0;
      bus_sel   <= 4'h0;
      bus_err   <= 1'b0;
      if_ack    <= 1'b0;
      if_rdata  <= 32'h0;
      mem_ack   <= 1'b0;
      mem_rdata <= 32'h0;
      tmo_q     <= 10'd0;
    end else begin
      if_ack  <= 1'b0;
      mem_ack <= 1'b0;
      bus_err <= 1'b0;
      if (grant_mem) begin
        bus_en    <= 1'b1;
        bus_rw    <= mem_rw;
        bus_addr  <= mem_addr;
        bus_wdata <= mem_wdata;
        bus_sel   <= mem_sel;
        tmo_q     <= 10'd0;
      end else if (grant_if) begin
        bus_en    <= 1'b1;
        bus_rw    <= 1'b0;
        bus_addr  <= if_addr;
        bus_wdata <= 32'h0;
        bus_sel   <= 4'hF;
        tmo_q     <= 10'd0;
      end else if (done || abort) begin
        bus_en  <= 1'b0;
        bus_err <= abort;
        if (state_q == BUSY_IF) begin
          if_ack   <= 1'b1;
          if_rdata <= done ? bus_rdata : 32'h0;
        end else begin
          mem_ack   <= 1'b1;
          mem_rdata <= done ? bus_rdata : 32'h0;
        end
      end else if (busy) begin
        tmo_q <= tmo_q + 10'd1;
      end
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Randomized scoreboard bench for bus_arbiter: bus slave model, requester drivers and ack monitor.
// Build with +define+ARB_STARVE_GUARD_EN to expect the starvation-guard grant order.
module tb_bus_arbiter;
  localparam int TIMEOUT      = 8;
  localparam int STARVE_LIMIT = 4;

  typedef struct {
    logic        to_mem;
    logic        rw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    int          delay;
    logic [31:0] rdata;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        mem_req;
  logic        mem_rw;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_sel;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        stallreq;
  logic        bus_en;
  logic        bus_rw;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_sel;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        bus_err;
  logic [1:0]  dbg_state;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  txn_t        bus_q[$];
  logic [32:0] if_exp_q[$];
  logic [32:0] mem_exp_q[$];
  logic [31:0] last_if = 32'h0;
  logic [31:0] last_mem = 32'h0;
  logic        slave_active = 1'b0;
  int          slave_k = 0;
  int          slave_end_cyc = 0;
  int          last_gap = 0;
  txn_t        cur;

  bus_arbiter #(.TIMEOUT(TIMEOUT), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .mem_req(mem_req), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_sel(mem_sel), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stallreq(stallreq),
    .bus_en(bus_en), .bus_rw(bus_rw), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_sel(bus_sel), .bus_rdata(bus_rdata), .bus_ack(bus_ack), .bus_err(bus_err),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic report();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  endtask

  task automatic push_txn(input logic to_mem, input logic rw, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] sel,
                          input int delay, input logic [31:0] rdata);
    txn_t t;
    t.to_mem = to_mem;
    t.rw     = rw;
    t.addr   = addr;
    t.wdata  = wdata;
    t.sel    = sel;
    t.delay  = delay;
    t.rdata  = rdata;
    bus_q.push_back(t);
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_if(input logic [31:0] addr);
    logic got = 1'b0;
    if_addr = addr;
    if_req  = 1'b1;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      if (if_ack) begin
        got    = 1'b1;
        if_req = 1'b0;
      end
    end
    if (!got) begin
      n_checks++;
      n_errors++;
      $display("FAIL if_ack_wait: no if_ack within budget for addr %h, required one", addr);
      if_req = 1'b0;
    end
  endtask

  task automatic do_mem(input logic rw, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] sel, input int n);
    int acks = 0;
    mem_rw    = rw;
    mem_addr  = addr;
    mem_wdata = wdata;
    mem_sel   = sel;
    mem_req   = 1'b1;
    for (int i = 0; i < 600 && acks < n; i++) begin
      @(negedge clk);
      if (mem_ack) begin
        acks++;
        if (acks == n) mem_req = 1'b0;
      end
    end
    if (acks < n) begin
      n_checks++;
      n_errors++;
      $display("FAIL mem_ack_wait: got %0d acks, required %0d", acks, n);
      mem_req = 1'b0;
    end
  endtask

  // ---------------- bus slave model ----------------
  // A transaction acked in busy cycle d completes if d <= TIMEOUT, otherwise aborts after TIMEOUT cycles.
  initial begin
    logic [32:0] e;
    int          exp_len;
    bus_ack   = 1'b0;
    bus_rdata = 32'h0;
    forever begin
      @(negedge clk);
      bus_ack   = 1'b0;
      bus_rdata = $urandom;
      if (bus_en && !slave_active) begin
        slave_active = 1'b1;
        slave_k      = 0;
        last_gap     = cyc - slave_end_cyc;
        if (bus_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL bus_start: transaction at addr %h, required none", bus_addr);
          cur.to_mem = 1'b1; cur.rw = bus_rw; cur.addr = bus_addr; cur.wdata = bus_wdata;
          cur.sel = bus_sel; cur.delay = 1; cur.rdata = 32'h0;
        end else begin
          cur = bus_q.pop_front();
          if (cur.delay <= TIMEOUT) e = {1'b0, cur.rdata};
          else e = {1'b1, 32'h0};
          if (cur.to_mem) mem_exp_q.push_back(e);
          else if_exp_q.push_back(e);
        end
      end
      if (slave_active && bus_en) begin
        slave_k++;
        check("bus_rw", {31'b0, bus_rw}, {31'b0, cur.rw});
        check("bus_addr", bus_addr, cur.addr);
        check("bus_sel", {28'b0, bus_sel}, {28'b0, cur.sel});
        if (cur.rw) check("bus_wdata", bus_wdata, cur.wdata);
        if (slave_k == cur.delay) begin
          bus_ack   = 1'b1;
          bus_rdata = cur.rdata;
        end
      end else if (slave_active) begin
        exp_len = (cur.delay < TIMEOUT) ? cur.delay : TIMEOUT;
        check("txn_length", slave_k, exp_len);
        slave_active  = 1'b0;
        slave_end_cyc = cyc;
      end else if ($urandom_range(0, 7) == 0) begin
        bus_ack = 1'b1;
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [32:0] e;
    logic        exp_err;
    logic        exp_stall;
    forever begin
      @(negedge clk);
      #1;
      exp_err   = 1'b0;
      exp_stall = (if_req & ~if_ack) | (mem_req & ~mem_ack);
      check("stallreq", {31'b0, stallreq}, {31'b0, exp_stall});
      if (if_ack) begin
        check("bus_en_at_if_ack", {31'b0, bus_en}, 32'd0);
        if (if_exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL if_ack: got ack with nothing outstanding, required 0");
        end else begin
          e = if_exp_q.pop_front();
          check("if_rdata", if_rdata, e[31:0]);
          exp_err = exp_err | e[32];
          last_if = e[31:0];
        end
      end else begin
        check("if_rdata_hold", if_rdata, last_if);
      end
      if (mem_ack) begin
        check("bus_en_at_mem_ack", {31'b0, bus_en}, 32'd0);
        if (mem_exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL mem_ack: got ack with nothing outstanding, required 0");
        end else begin
          e = mem_exp_q.pop_front();
          check("mem_rdata", mem_rdata, e[31:0]);
          exp_err  = exp_err | e[32];
          last_mem = e[31:0];
        end
      end else begin
        check("mem_rdata_hold", mem_rdata, last_mem);
      end
      check("bus_err", {31'b0, bus_err}, {31'b0, exp_err});
    end
  end

  initial begin
    #300000;
    n_errors++;
    $display("FAIL watchdog: still running at %0t, required finish", $time);
    report();
  end

  // ---------------- stimulus ----------------
  initial begin
    if_req = 1'b0; if_addr = 32'h0;
    mem_req = 1'b0; mem_rw = 1'b0; mem_addr = 32'h0; mem_wdata = 32'h0; mem_sel = 4'h0;
    #1 rst = 1'b0;
    #2;
    check("rst_bus_en", {31'b0, bus_en}, 32'd0);
    check("rst_if_ack", {31'b0, if_ack}, 32'd0);
    check("rst_mem_ack", {31'b0, mem_ack}, 32'd0);
    check("rst_bus_err", {31'b0, bus_err}, 32'd0);
    check("rst_bus_addr", bus_addr, 32'h0);
    check("rst_state", {30'b0, dbg_state}, 32'd0);
    @(negedge clk);
    #2 rst = 1'b1;

    // single IF read
    @(negedge clk);
    push_txn(1'b0, 1'b0, 32'h0000_0100, 32'h0, 4'hF, 3, 32'h2408_0005);
    do_if(32'h0000_0100);

    // simultaneous requests: MEM write first, then IF after one idle cycle
    @(negedge clk);
    push_txn(1'b1, 1'b1, 32'h001F_FFFC, 32'hDEAD_BEEF, 4'b0011, 2, 32'h1111_2222);
    push_txn(1'b0, 1'b0, 32'h0000_0104, 32'h0, 4'hF, 1, 32'h3333_4444);
    fork
      do_mem(1'b1, 32'h001F_FFFC, 32'hDEAD_BEEF, 4'b0011, 1);
      do_if(32'h0000_0104);
    join
    check("idle_gap", last_gap, 32'd1);

    // timeout abort on MEM and IF, then the ack-on-timeout race
    @(negedge clk);
    push_txn(1'b1, 1'b0, 32'h0000_0800, 32'h0, 4'hF, 20, 32'h5555_6666);
    do_mem(1'b0, 32'h0000_0800, 32'h0, 4'hF, 1);
    @(negedge clk);
    push_txn(1'b0, 1'b0, 32'h0000_0200, 32'h0, 4'hF, 15, 32'h7777_8888);
    do_if(32'h0000_0200);
    @(negedge clk);
    push_txn(1'b1, 1'b0, 32'h0000_0804, 32'h0, 4'hF, TIMEOUT, 32'hCAFE_F00D);
    do_mem(1'b0, 32'h0000_0804, 32'h0, 4'hF, 1);

    // randomized traffic: 0 = IF only, 1 = MEM only, 2 = both together
    for (int t = 0; t < 40; t++) begin
      int          kind;
      logic [31:0] ia;
      logic [31:0] ma;
      logic [31:0] wd;
      logic        mrw;
      logic [3:0]  ms;
      kind = $urandom_range(0, 2);
      ia   = $urandom & 32'hFFFF_FFFC;
      ma   = $urandom & 32'h001F_FFFC;
      wd   = $urandom;
      mrw  = 1'($urandom_range(0, 1));
      ms   = 4'($urandom_range(1, 15));
      @(negedge clk);
      if (kind != 0) push_txn(1'b1, mrw, ma, wd, ms, $urandom_range(1, 10), $urandom);
      if (kind != 1) push_txn(1'b0, 1'b0, ia, 32'h0, 4'hF, $urandom_range(1, 10), $urandom);
      fork
        if (kind != 1) do_if(ia);
        if (kind != 0) do_mem(mrw, ma, wd, ms, 1);
      join
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // MEM held for six grants while IF waits
    @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      logic is_if;
`ifdef ARB_STARVE_GUARD_EN
      is_if = (i == STARVE_LIMIT);
`else
      is_if = (i == 6);
`endif
      if (is_if) push_txn(1'b0, 1'b0, 32'h0000_0300, 32'h0, 4'hF, $urandom_range(1, 3), $urandom);
      else push_txn(1'b1, 1'b0, 32'h0000_0400, 32'h0, 4'hF, $urandom_range(1, 3), $urandom);
    end
    fork
      do_mem(1'b0, 32'h0000_0400, 32'h0, 4'hF, 6);
      do_if(32'h0000_0300);
    join

    // asynchronous reset in the middle of a MEM transaction
    @(negedge clk);
    push_txn(1'b1, 1'b0, 32'h0000_2000, 32'h0, 4'hF, 30, 32'h1234_5678);
    mem_rw = 1'b0; mem_addr = 32'h0000_2000; mem_wdata = 32'h0; mem_sel = 4'hF; mem_req = 1'b1;
    for (int i = 0; i < 20 && !bus_en; i++) @(negedge clk);
    check("reset_setup_bus_en", {31'b0, bus_en}, 32'd1);
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b0;
    mem_req = 1'b0;
    slave_active = 1'b0;
    bus_ack = 1'b0;
    mem_exp_q.delete();
    bus_q.delete();
    last_if = 32'h0;
    last_mem = 32'h0;
    #1;
    check("async_rst_bus_en", {31'b0, bus_en}, 32'd0);
    check("async_rst_mem_ack", {31'b0, mem_ack}, 32'd0);
    check("async_rst_if_rdata", if_rdata, 32'h0);
    check("async_rst_mem_rdata", mem_rdata, 32'h0);
    check("async_rst_bus_addr", bus_addr, 32'h0);
    check("async_rst_state", {30'b0, dbg_state}, 32'd0);
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    push_txn(1'b1, 1'b0, 32'h0000_2004, 32'h0, 4'hF, 2, 32'h0BAD_F00D);
    do_mem(1'b0, 32'h0000_2004, 32'h0, 4'hF, 1);

    repeat (5) @(negedge clk);
    check("bus_q_drained", bus_q.size(), 32'd0);
    check("if_exp_drained", if_exp_q.size(), 32'd0);
    check("mem_exp_drained", mem_exp_q.size(), 32'd0);
    report();
  end

endmodule
